enemy_lane_scheduler: RTL and testbench
=======================================

// Module: enemy_lane_scheduler
// PURPOSE
//  Sequences the two enemy sprite slots along their lanes: spawns enemies on a
//  timed schedule, steps each lane position on the animation tick, and retires
//  enemies on player hit or on reaching the lane end. Drives the pos_0/pos_1,
//  hit_0/hit_1 inputs of the enemy renderers and the player-damage pulse.
//  Sits between the game-tick divider and the per-enemy render blocks.
// PARAMETERS
//  END_POS    20     last lane position (5-bit); pos 0 = slot inactive/off-screen
//  SPAWN_GAP  8      ticks between spawns (1..31)
//  HIT_TICKS  4      ticks a hit enemy stays frozen on screen before retiring (1..15)
//  LFSR_SEED  8'hA5  reset value of spawn LFSR (nonzero); used only with the macro
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  tick       in   1   one-cycle step strobe (synchronised animation tick)
//  run        in   1   1 = game running; 0 = freeze all counters/positions
//  shot_0     in   1   one-cycle pulse: player shot lands on slot 0
//  shot_1     in   1   one-cycle pulse: player shot lands on slot 1
//  pos_0      out  5   slot 0 lane position (0 = inactive, 1..END_POS)
//  pos_1      out  5   slot 1 lane position
//  hit_0      out  1   slot 0 in HIT state (renderer shows hit sprite)
//  hit_1      out  1   slot 1 in HIT state
//  damage     out  1   one-cycle pulse: at least one enemy reached lane end
//  score_inc  out  1   one-cycle pulse per cycle in which >=1 slot enters HIT
// BEHAVIOUR
//  - Reset: pos_*=0, hit_*=0, damage=0, score_inc=0, both slots IDLE,
//    spawn counter=SPAWN_GAP, LFSR=LFSR_SEED. Async assert, sync release.
//  - All state advances only on cycles with run=1; run=0 holds everything;
//    damage/score_inc forced 0; shot_* ignored.
//  - Per-slot FSM: IDLE -> WALK -> {HIT, IDLE}; HIT -> IDLE.
//    IDLE: pos=0. WALK: on tick, pos<END_POS -> pos+1; pos==END_POS -> IDLE,
//    pos=0, damage=1 next cycle. shot_n in WALK -> HIT next cycle, pos frozen,
//    hit counter=HIT_TICKS, score_inc=1 for one cycle.
//    HIT: hit_n=1; counter decrements per tick; reaching 0 -> IDLE, pos=0.
//    shot_n in IDLE or HIT ignored.
//  - Spawn: spawn counter decrements per tick while >0. At 0 with an IDLE slot:
//    lowest-index IDLE slot -> WALK at pos=1 on that tick, counter reloads.
//    At 0 with no IDLE slot: counter holds 0; spawn occurs on first tick a slot
//    is IDLE at tick time (a slot freed the same tick is not reused that tick).
//  - Simultaneous: shot_n and end-of-lane tick same cycle -> shot wins (HIT, no
//    damage). Both slots end same tick -> single one-cycle damage pulse.
//    Both shot same cycle -> single score_inc pulse.
//  - Latency: outputs registered; pos/hit/damage/score_inc change 1 cycle after
//    the causing tick/shot edge.
// CONFIGURATION
//  ENEMY_RANDOM_SPAWN_EN defined: 8-bit Galois LFSR (taps 8,6,5,4) steps every
//    tick; reload value = SPAWN_GAP + lfsr[2:0] (6-bit, no overflow for gap<=24).
//  Not defined: no LFSR; reload value = SPAWN_GAP exactly.
// TESTING (macro undefined unless noted, defaults)
//  1. Reset, run=1, 8 ticks -> pos_0=1 after 8th tick, pos_1=0.
//  2. Continue 19 more ticks, no shots -> pos_0 walks to 20, next tick
//     damage=1 for exactly one cycle, pos_0=0.
//  3. shot_0 with pos_0=5 -> hit_0=1, score_inc one-cycle pulse, pos_0 stays 5
//     for 4 ticks, then pos_0=0, hit_0=0.
//  4. Both slots WALK, spawn counter expires -> counter holds 0, no spawn; shot
//     slot 0, after 4 ticks slot 0 IDLE, next tick slot 0 spawns at pos=1.
//  5. shot_0 same cycle as tick with pos_0=20 -> HIT, damage stays 0;
//     run=0 mid-walk for 10 ticks -> pos unchanged; rst mid-HIT -> all outputs 0.
//  6. Macro defined, LFSR_SEED=8'hA5 -> spawn gaps match model sequence
//     SPAWN_GAP+lfsr[2:0], all within 8..15.

Source files
------------

// File: rtl/enemy_lane_scheduler.sv
// Two-slot enemy lane sequencer: timed spawns, tick-driven walk, hit freeze and retire.
// Optional macro ENEMY_RANDOM_SPAWN_EN adds an LFSR jitter to the spawn reload.
module enemy_lane_scheduler #(
   parameter logic [4:0]  END_POS   = 5'd20,
   parameter int unsigned SPAWN_GAP = 8,
   parameter int unsigned HIT_TICKS = 4
`ifdef ENEMY_RANDOM_SPAWN_EN
   ,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       run,
   input  logic       shot_0,
   input  logic       shot_1,
   output logic [4:0] pos_0,
   output logic [4:0] pos_1,
   output logic       hit_0,
   output logic       hit_1,
   output logic       damage,
   output logic       score_inc
);

   localparam logic [5:0] GAP  = 6'(SPAWN_GAP);
   localparam logic [3:0] HITN = 4'(HIT_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_HIT} slot_state_t;

   slot_state_t state_q [2];
   slot_state_t state_d [2];
   logic [4:0]  pos_q   [2];
   logic [4:0]  pos_d   [2];
   logic [3:0]  hcnt_q  [2];
   logic [3:0]  hcnt_d  [2];
   logic [5:0]  spawn_q, spawn_d, spawn_dec, reload;
   logic        damage_q, damage_d;
   logic        score_q, score_d;
   logic [1:0]  shot;

   assign shot = {shot_1, shot_0};

`ifdef ENEMY_RANDOM_SPAWN_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Galois form of x^8 + x^6 + x^5 + x^4 + 1, shifting right
   always_comb begin
      lfsr_d = lfsr_q;
      if (run && tick)
         lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      reload = GAP + {3'b000, lfsr_q[2:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign reload = GAP;
`endif

   always_comb begin
      damage_d  = 1'b0;
      score_d   = 1'b0;
      spawn_d   = spawn_q;
      spawn_dec = (spawn_q != '0) ? spawn_q - 6'd1 : '0;
      for (int unsigned i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         pos_d[i]   = pos_q[i];
         hcnt_d[i]  = hcnt_q[i];
      end
      if (run) begin
         for (int unsigned i = 0; i < 2; i++) begin
            case (state_q[i])
               S_WALK: begin
                  if (shot[i]) begin
                     state_d[i] = S_HIT;
                     hcnt_d[i]  = HITN;
                     score_d    = 1'b1;
                  end else if (tick) begin
                     if (pos_q[i] == END_POS) begin
                        state_d[i] = S_IDLE;
                        pos_d[i]   = '0;
                        damage_d   = 1'b1;
                     end else begin
                        pos_d[i] = pos_q[i] + 5'd1;
                     end
                  end
               end
               S_HIT: begin
                  if (tick) begin
                     hcnt_d[i] = hcnt_q[i] - 4'd1;
                     if (hcnt_q[i] <= 4'd1) begin
                        state_d[i] = S_IDLE;
                        pos_d[i]   = '0;
                        hcnt_d[i]  = '0;
                     end
                  end
               end
               default: ;
            endcase
         end
         // Idle check uses the registered state, so a slot freed this tick waits a tick
         if (tick) begin
            spawn_d = spawn_dec;
            if (spawn_dec == '0) begin
               if (state_q[0] == S_IDLE) begin
                  state_d[0] = S_WALK;
                  pos_d[0]   = 5'd1;
                  spawn_d    = reload;
               end else if (state_q[1] == S_IDLE) begin
                  state_d[1] = S_WALK;
                  pos_d[1]   = 5'd1;
                  spawn_d    = reload;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= S_IDLE;
            pos_q[i]   <= '0;
            hcnt_q[i]  <= '0;
         end
         spawn_q  <= GAP;
         damage_q <= 1'b0;
         score_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            pos_q[i]   <= pos_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
         spawn_q  <= spawn_d;
         damage_q <= damage_d;
         score_q  <= score_d;
      end
   end

   assign pos_0     = pos_q[0];
   assign pos_1     = pos_q[1];
   assign hit_0     = (state_q[0] == S_HIT);
   assign hit_1     = (state_q[1] == S_HIT);
   assign damage    = damage_q;
   assign score_inc = score_q;

endmodule

// File: tb/tb_enemy_lane_scheduler.sv
// Bench for enemy_lane_scheduler: directed vector table, corner sequences, random vs model.
module tb_enemy_lane_scheduler;

   localparam int END_POS   = 20;
   localparam int SPAWN_GAP = 8;
   localparam int HIT_TICKS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0, run = 1'b0, shot_0 = 1'b0, shot_1 = 1'b0;
   logic [4:0] pos_0, pos_1;
   logic       hit_0, hit_1, damage, score_inc;

   int checks = 0;
   int errors = 0;

   enemy_lane_scheduler dut (
      .clk(clk), .rst(rst), .tick(tick), .run(run),
      .shot_0(shot_0), .shot_1(shot_1),
      .pos_0(pos_0), .pos_1(pos_1), .hit_0(hit_0), .hit_1(hit_1),
      .damage(damage), .score_inc(score_inc)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 walking, 2 frozen after a hit
   int m_mode [2];
   int m_pos  [2];
   int m_hc   [2];
   int m_spawn;
   int m_lfsr;
   bit m_dmg, m_score;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_pos[i] = 0; m_hc[i] = 0;
      end
      m_spawn = SPAWN_GAP;
      m_lfsr  = 'hA5;
      m_dmg   = 0;
      m_score = 0;
   endfunction

   function automatic void model_step(bit t, bit s0, bit s1, bit r);
      bit was_idle [2];
      bit sh [2];
      int rl;
      m_dmg = 0;
      m_score = 0;
      if (!r) return;
      sh[0] = s0; sh[1] = s1;
      for (int i = 0; i < 2; i++) was_idle[i] = (m_mode[i] == 0);
      for (int i = 0; i < 2; i++) begin
         if (m_mode[i] == 1) begin
            if (sh[i]) begin
               m_mode[i] = 2; m_hc[i] = HIT_TICKS; m_score = 1;
            end else if (t) begin
               if (m_pos[i] == END_POS) begin
                  m_mode[i] = 0; m_pos[i] = 0; m_dmg = 1;
               end else m_pos[i]++;
            end
         end else if (m_mode[i] == 2 && t) begin
            m_hc[i]--;
            if (m_hc[i] == 0) begin
               m_mode[i] = 0; m_pos[i] = 0;
            end
         end
      end
      if (t) begin
         rl = SPAWN_GAP;
`ifdef ENEMY_RANDOM_SPAWN_EN
         rl = SPAWN_GAP + (m_lfsr % 8);
         m_lfsr = (m_lfsr / 2) ^ (((m_lfsr % 2) == 1) ? 'hB8 : 0);
`endif
         if (m_spawn > 0) m_spawn--;
         if (m_spawn == 0) begin
            for (int i = 0; i < 2; i++) begin
               if (was_idle[i]) begin
                  m_mode[i] = 1; m_pos[i] = 1; m_spawn = rl;
                  break;
               end
            end
         end
      end
   endfunction

   function automatic logic [13:0] model_vec();
      return {5'(m_pos[0]), 5'(m_pos[1]), m_mode[0] == 2, m_mode[1] == 2, m_dmg, m_score};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {pos_0, pos_1, hit_0, hit_1, damage, score_inc};
   endfunction

   task automatic compare(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input bit t, input bit s0, input bit s1, input bit r);
      tick = t; shot_0 = s0; shot_1 = s1; run = r;
      @(posedge clk);
      model_step(t, s0, s1, r);
      #1;
      tick = 0; shot_0 = 0; shot_1 = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick = 0; shot_0 = 0; shot_1 = 0; run = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      compare("reset_state", dut_vec(), 14'h0);
      rst = 1'b0;
   endtask

   typedef struct {
      int         n;
      bit         t, s0, s1, r;
      logic [4:0] p0, p1;
      bit         h0, h1, dmg, sc;
   } vec_t;

   vec_t vecs [19];

   initial begin
      vecs[0]  = '{1,  0,0,0,1,  0, 0, 0,0,0,0};
      vecs[1]  = '{7,  1,0,0,1,  0, 0, 0,0,0,0};
      vecs[2]  = '{1,  1,0,0,1,  1, 0, 0,0,0,0};
      vecs[3]  = '{18, 1,0,0,1, 19,11, 0,0,0,0};
      vecs[4]  = '{1,  1,0,0,1, 20,12, 0,0,0,0};
      vecs[5]  = '{1,  1,0,0,1,  0,13, 0,0,1,0};
      vecs[6]  = '{1,  0,0,0,1,  0,13, 0,0,0,0};
      vecs[7]  = '{1,  1,0,0,1,  1,14, 0,0,0,0};
      vecs[8]  = '{4,  1,0,0,1,  5,18, 0,0,0,0};
      vecs[9]  = '{1,  0,1,0,1,  5,18, 1,0,0,1};
      vecs[10] = '{1,  0,0,0,1,  5,18, 1,0,0,0};
      vecs[11] = '{3,  1,0,0,1,  5, 0, 1,0,1,0};
      vecs[12] = '{1,  1,0,0,1,  0, 1, 0,0,0,0};
      vecs[13] = '{10, 1,1,0,0,  0, 1, 0,0,0,0};
      vecs[14] = '{1,  1,0,0,1,  0, 2, 0,0,0,0};
      vecs[15] = '{7,  1,0,0,1,  1, 9, 0,0,0,0};
      vecs[16] = '{1,  0,1,1,1,  1, 9, 1,1,0,1};
      vecs[17] = '{1,  0,0,0,1,  1, 9, 1,1,0,0};
      vecs[18] = '{4,  1,0,0,1,  0, 0, 0,0,0,0};

`ifndef ENEMY_RANDOM_SPAWN_EN
      do_reset();
      for (int i = 0; i < 19; i++) begin
         for (int k = 0; k < vecs[i].n; k++) step(vecs[i].t, vecs[i].s0, vecs[i].s1, vecs[i].r);
         compare($sformatf("vec%0d", i), dut_vec(),
                 {vecs[i].p0, vecs[i].p1, vecs[i].h0, vecs[i].h1, vecs[i].dmg, vecs[i].sc});
      end

      // Shot on the same tick that would retire at lane end: hit wins, no damage
      do_reset();
      repeat (27) step(1, 0, 0, 1);
      compare("at_end_pos", {9'h0, pos_0}, 14'd20);
      step(1, 1, 0, 1);
      compare("shot_beats_end", {9'h0, pos_0, hit_0, damage, score_inc}, {9'h0, 5'd20, 3'b101});
      repeat (4) step(1, 0, 0, 1);
      compare("hit_retire", {8'h0, pos_0, hit_0}, 14'h0);

      // Freeze with run low, then async reset while frozen in HIT
      do_reset();
      repeat (10) step(1, 0, 0, 1);
      compare("walk_pos3", {9'h0, pos_0}, 14'd3);
      repeat (10) step(1, 1, 1, 0);
      compare("run_freeze", {9'h0, pos_0}, 14'd3);
      step(0, 1, 0, 1);
      compare("hit_after_freeze", {8'h0, pos_0, hit_0}, {8'h0, 5'd3, 1'b1});
      #2 rst = 1'b1;
      #1 compare("async_reset", dut_vec(), 14'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
`endif

      // Randomized run against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0);
         compare("random", dut_vec(), model_vec());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
